imm_decode_ctrl: RTL and testbench

IMM_DECODE_CTRL -- requirements
Module: imm_decode_ctrl

---
 rtl/imm_decode_ctrl.sv | 149 ++++++++++++++
 tb/tb_imm_decode_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl.sv
// Instruction classifier and immediate capture for decode, with a 2-entry
// in-order head/skid buffer between fetch and the decode consumer.
module imm_decode_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [63:0]      in_pc,
    input  logic             flush,
    output logic [31:0]      gen_instr,
    output logic [1:0]       gen_src,
    input  logic [63:0]      gen_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [63:0]      out_pc,
    output logic [63:0]      out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2,
                           T_B = 3'd3, T_J = 3'd4, T_U = 3'd5;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        illegal;
    } entry_t;

    state_t state, state_nxt;
    entry_t head, skid, new_ent;
    logic   cls_ill;
    logic [2:0] cls_type;
    logic   push, pop, ld_head_new, ld_skid, head_from_skid;

    always_comb begin
        cls_type = T_NONE;
        cls_ill  = 1'b0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b0001111, 7'b1110011: cls_type = T_I;
            7'b0100011:                         cls_type = T_S;
            7'b1100011:                         cls_type = T_B;
            7'b1101111:                         cls_type = T_J;
            7'b0110111, 7'b0010111:             cls_type = T_U;
            7'b0110011, 7'b0111011:             cls_type = T_NONE;
            default:                            cls_ill  = 1'b1;
        endcase
    end

    assign gen_instr = in_instr;

    always_comb begin
        case (cls_type)
            T_S:     gen_src = 2'b01;
            T_B:     gen_src = 2'b10;
            T_J:     gen_src = 2'b11;
            default: gen_src = 2'b00;
        endcase
    end

    always_comb begin
        new_ent.instr   = in_instr;
        new_ent.pc      = in_pc;
        new_ent.typ     = cls_type;
        new_ent.illegal = cls_ill;
        case (cls_type)
            T_I, T_S, T_B, T_J: new_ent.imm = gen_imm;
            T_U:     new_ent.imm = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
            default: new_ent.imm = 64'b0;
        endcase
    end

    assign out_valid = (state != EMPTY);
    // Flush kills the handshake so neither the buffer nor the counter see it.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        ld_head_new    = 1'b0;
        ld_skid        = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    state_nxt   = ONE;
                    ld_head_new = 1'b1;
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt = TWO;
                        ld_skid   = 1'b1;
                    end else if (pop && !push) begin
                        state_nxt = EMPTY;
                    end else if (push && pop) begin
                        ld_head_new = 1'b1;
                    end
                end
                TWO: if (pop) begin
                    state_nxt      = ONE;
                    head_from_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            skid     <= '0;
            in_ready <= 1'b0;
        end else begin
            if (ld_head_new)         head <= new_ent;
            else if (head_from_skid) head <= skid;
            if (ld_skid)             skid <= new_ent;
            in_ready <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (push && cls_ill && (illegal_cnt != {CNT_W{1'b1}}))
            illegal_cnt <= illegal_cnt + 1'b1;
    end

    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    assign out_imm     = head.imm;
    assign out_type    = head.typ;
    assign out_illegal = head.illegal;
endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Scoreboard bench for imm_decode_ctrl: a reference classifier/immediate model
// queues expectations at input handshakes and checks them at output pops.
module tb_imm_decode_ctrl;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [31:0]   in_instr = '0, gen_instr, out_instr;
    logic [63:0]   in_pc = '0, gen_imm, out_pc, out_imm;
    logic [1:0]    gen_src;
    logic          out_valid, out_ready = 1'b1, out_illegal;
    logic [2:0]    out_type;
    logic [CW-1:0] illegal_cnt;

    imm_decode_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .gen_instr(gen_instr), .gen_src(gen_src), .gen_imm(gen_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_imm(out_imm), .out_type(out_type),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    exp_t          q[$];
    int            n_chk = 0, n_err = 0;
    logic [CW-1:0] cnt_m = '0;
    logic          mon_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_ill(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
            7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] model_type(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73: return 3'd1;
            7'h23: return 3'd2;
            7'h63: return 3'd3;
            7'h6F: return 3'd4;
            7'h37, 7'h17: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_src(input logic [2:0] t);
        case (t)
            3'd2: return 2'b01;
            3'd3: return 2'b10;
            3'd4: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [63:0] gen_model(input logic [31:0] i, input logic [1:0] s);
        case (s)
            2'b00: return {{52{i[31]}}, i[31:20]};
            2'b01: return {{52{i[31]}}, i[31:25], i[11:7]};
            2'b10: return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] i);
        logic [2:0] t;
        t = model_type(i);
        if (t >= 3'd1 && t <= 3'd4) return gen_model(i, model_src(t));
        if (t == 3'd5) return {{32{i[31]}}, i[31:12], 12'b0};
        return 64'b0;
    endfunction

    // Immediate generator stand-in: a wrong gen_src yields a wrong imm.
    assign gen_imm = gen_model(gen_instr, gen_src);

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && mon_en) begin
            chk("illegal_cnt", 64'(illegal_cnt), 64'(cnt_m));
            if (flush) begin
                q.delete();
            end else begin
                chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
                if (out_valid && out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_instr", 64'(out_instr), 64'(e.instr));
                    chk("out_pc", out_pc, e.pc);
                    chk("out_imm", out_imm, e.imm);
                    chk("out_type", 64'(out_type), 64'(e.typ));
                    chk("out_illegal", 64'(out_illegal), 64'(e.ill));
                end
                if (in_valid) begin
                    chk("gen_src", 64'(gen_src), 64'(model_src(model_type(in_instr))));
                    chk("gen_instr", 64'(gen_instr), 64'(in_instr));
                end
                if (in_valid && in_ready) begin
                    e.instr = in_instr;
                    e.pc    = in_pc;
                    e.imm   = model_imm(in_instr);
                    e.typ   = model_type(in_instr);
                    e.ill   = model_ill(in_instr);
                    q.push_back(e);
                    if (e.ill && cnt_m != {CW{1'b1}}) cnt_m = cnt_m + 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] i, input logic [63:0] pc);
        bit hs = 1'b0;
        in_valid = 1'b1;
        in_instr = i;
        in_pc    = pc;
        for (int k = 0; k < 50; k++) begin
            hs = in_ready;
            step();
            if (hs) break;
        end
        if (!hs) chk("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 30 && q.size() != 0; k++) step();
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    logic [6:0] ops [16] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
                             7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B, 7'h7F, 7'h00, 7'h0B};

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_type", 64'(out_type), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        chk("ready_pre_edge", 64'(in_ready), 64'd0);
        step();
        chk("ready_post_edge", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        // addi x1,x0,-1 with one-cycle latency
        push(32'hFFF00093, 64'h1000);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_type", 64'(out_type), 64'd1);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        // sw then jal held in the buffer
        out_ready = 1'b0;
        push(32'h00112423, 64'h1004);
        push(32'hFFDFF06F, 64'h1008);
        chk("two_in_ready", 64'(in_ready), 64'd0);
        chk("two_head_instr", 64'(out_instr), 64'h00112423);
        chk("sw_imm", out_imm, 64'h8);
        drain();

        // lui
        push(32'h123450B7, 64'h100C);
        chk("lui_type", 64'(out_type), 64'd5);
        chk("lui_imm", out_imm, 64'h0000_0000_1234_5000);
        chk("lui_illegal", 64'(out_illegal), 64'd0);
        drain();

        // Illegal encodings
        push(32'h00000000, 64'h1010);
        push(32'hFFFFFFFF, 64'h1014);
        drain();
        step();
        chk("cnt_two", 64'(illegal_cnt), 64'd2);

        // Flush from TWO with an incoming instruction
        out_ready = 1'b0;
        push(32'h00500093, 64'h2000);
        push(32'h00600113, 64'h2004);
        in_valid = 1'b1; in_instr = 32'h0000_0000; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush2_valid", 64'(out_valid), 64'd0);
        chk("flush2_ready", 64'(in_ready), 64'd1);
        chk("flush2_cnt", 64'(illegal_cnt), 64'd2);

        // Flush from ONE while an illegal handshake would complete
        push(32'h00700193, 64'h2008);
        in_valid = 1'b1; in_instr = 32'hFFFF_FFFF; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush1_valid", 64'(out_valid), 64'd0);
        chk("flush1_cnt", 64'(illegal_cnt), 64'd2);
        step();
        chk("flush1_gone", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // Random traffic with backpressure and occasional flush
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = {25'($urandom), ops[$urandom_range(0, 15)]};
            in_pc     = {32'h0, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0;
        drain();

        // Saturation of the illegal counter
        for (int n = 0; n < 10; n++) push(32'h0000_000B, 64'h3000 + 64'(n));
        drain();
        step();
        chk("cnt_sat", 64'(illegal_cnt), 64'd7);

        // Asynchronous reset while holding two entries
        out_ready = 1'b0;
        push(32'h00112423, 64'h4000);
        push(32'h00000000, 64'h4004);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_cnt", 64'(illegal_cnt), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        chk("arst_instr", 64'(out_instr), 64'd0);
        q.delete();
        cnt_m = '0;
        step();
        rst_n = 1'b1;
        step();
        chk("arst_ready_rise", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        push(32'h123450B7, 64'h5000);
        drain();
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
